mem_byte_ctrl: RTL
==================

Name: mem_byte_ctrl

Overview:
- Consumer of the clock divider's one-cycle-in-eight strobe (dclk, wired to tick here).
- Serialises 8/16/32-bit CPU load/store requests into byte-wide accesses on the single-port 8-bit RAM bus.
- Advances exactly one byte per tick.
- Sits between the CPU memory stage / instruction fetch arbiter and the byte RAM.

Parameters:
- ADDR_W, 17, width of byte address presented to RAM (128 KiB).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  pacing strobe from clock divider; high for one clk cycle per RAM step.
- req_valid  in  1  request present.
- req_ready  out  1  high when block can accept a request (combinational: state==IDLE).
- req_we  in  1  1=store, 0=load.
- req_size  in  2  SZ_B=00 (1 byte), SZ_H=01 (2), SZ_W=10 (4); 11 treated as SZ_W.
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- req_addr  in  32  byte address; low ADDR_W bits used.
- req_wdata  in  32  store data, byte 0 = bits 7:0, little-endian.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  extended load data; valid with resp_valid, held until next load completes.
- mem_a  out  ADDR_W  RAM byte address.
- mem_wr  out  1  RAM write enable.
- mem_dout  out  8  RAM write data.
- mem_din  in  8  RAM read data; valid at the tick following the tick that presented its address.

Behaviour:
- Reset (rst low, async): state=IDLE; mem_a=0, mem_wr=0, mem_dout=0, resp_valid=0, resp_rdata=0, byte index=0. Any in-flight access is abandoned; no response is issued.
- Acceptance: on any clk edge with req_valid & req_ready, independent of tick.
  - Latch we, size, signed, addr, wdata.
  - Set N = 1/2/4.
  - state becomes BUSY, index i=0.
- A tick on the accept cycle is not used.
- BUSY, per tick edge (all mem_* registered, change only on tick edges):
  - If i<N: mem_a=addr+i (mod 2^ADDR_W), mem_wr=we, mem_dout=wdata byte i.
  - If load and i>=1: capture mem_din into data byte i-1.
  - i increments.
  - If i==N (the N+1-th tick): mem_wr=0, mem_a holds; load captures byte N-1; resp_valid=1; state=IDLE.
- No ticks between BUSY steps: state and outputs hold.
- Latency: exactly N+1 ticks after acceptance for both loads and stores. mem_wr stays high for the full tick interval of each store byte.
- resp_valid is high for exactly one clk cycle (the cycle after the final tick edge). There is no backpressure on the response.
- resp_rdata: bytes above N are filled with sign bit (byte N-1 bit 7) if signed, else 0. Stores leave resp_rdata unchanged.
- Back-to-back: req_ready is 1 in the same cycle resp_valid is 1; a request accepted then starts at the next tick.
- No alignment check: misaligned addresses increment bytewise. Address wrap at 2^ADDR_W-1 -> 0.
- req_valid while BUSY is ignored; the requester holds it.
- tick held high continuously is legal: one byte per clk.

Decomposition:
- Shared package (mem_defs):
  - SZ_B, SZ_H, SZ_W encodings.
  - State encodings IDLE, BUSY.
  - ADDR_W default.
- One natural sub-module, load_ext: combinational byte-assembly plus sign/zero extension by size/signed. Reused by the cache refill path.

Test Plan:
- Word store 0xDEADBEEF at 0x00100, tick every 8 clks -> bytes EF,BE,AD,DE written at 0x100..0x103 on ticks 1-4; resp_valid at tick 5; mem_wr low after.
- Signed byte load at 0x00200, RAM byte 0x80 -> resp_rdata=0xFFFFFF80 after 2 ticks. Unsigned halfword 0x8001 at 0x202 -> 0x00008001 after 3 ticks.
- Word load at addr 0x1FFFE (wrap) -> mem_a sequence 1FFFE,1FFFF,00000,00001; bytes assembled little-endian.
- rst low mid-store after byte 1 -> mem_wr=0 immediately; no resp_valid; req_ready=1; a new byte load then completes normally.
- Request arriving in the resp_valid cycle -> accepted that cycle; its first access on the next tick, not the same tick.
- tick tied high, word load -> resp_valid exactly 5 clks after acceptance.

Source files
------------

// File: rtl/mem_defs.sv
// Shared definitions for the byte-serial memory controller and its helpers.
//   SZ_*       : request size encodings (11 behaves as a word)
//   ST_*       : controller state encodings
//   ADDR_W_DEF : default RAM byte-address width (128 KiB)
package mem_defs;

  localparam int unsigned ADDR_W_DEF = 17;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Latched request attributes (address is kept separately at RAM width)
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } req_ctrl_t;

  // Number of byte accesses for a size code
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load-data extension: keeps the low 1/2/4 bytes of an assembled
// little-endian word and fills the rest with sign or zeros.
//   raw    : assembled bytes, byte 0 in bits 7:0
//   size   : SZ_B / SZ_H / SZ_W (11 treated as word)
//   sgn    : 1 = sign-extend, 0 = zero-extend
//   data_c : extended result (combinational)
module load_ext
  import mem_defs::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data_c
);

  always_comb begin
    data_c = raw;
    case (size)
      SZ_B:    data_c = {{24{sgn & raw[7]}},  raw[7:0]};
      SZ_H:    data_c = {{16{sgn & raw[15]}}, raw[15:0]};
      default: data_c = raw;
    endcase
  end

endmodule

// File: rtl/mem_byte_ctrl.sv
// Serialises 8/16/32-bit CPU loads/stores into byte accesses on an 8-bit
// single-port RAM, advancing one byte per tick.
//   clk, rst            : clock, async active-low reset
//   tick                : pacing strobe, one RAM step per high cycle
//   req_*               : request handshake and payload (req_ready = idle)
//   resp_valid/rdata    : one-cycle completion pulse, extended load data
//   mem_a/wr/dout, din  : byte RAM bus (din valid one tick after address)
module mem_byte_ctrl
  import mem_defs::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din
);

  logic [0:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  req_ctrl_t         cur_q, cur_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       raw_q, raw_d;
  logic [ADDR_W-1:0] mem_a_d;
  logic              mem_wr_d;
  logic [7:0]        mem_dout_d;
  logic              resp_valid_d;
  logic [31:0]       resp_rdata_d;

  logic [2:0]        n_c;
  logic [1:0]        cap_idx_c;
  logic [31:0]       raw_cap_c;
  logic [31:0]       ext_c;

  // Address bits above the RAM width are intentionally dropped
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  assign req_ready = (state_q == ST_IDLE);
  assign n_c       = size_bytes(cur_q.size);

  // Read data arriving now belongs to the byte presented one tick ago
  always_comb begin
    cap_idx_c = 2'(idx_q - 3'd1);
    raw_cap_c = raw_q;
    raw_cap_c[{cap_idx_c, 3'b000} +: 8] = mem_din;
  end

  load_ext u_load_ext (
    .raw    (raw_cap_c),
    .size   (cur_q.size),
    .sgn    (cur_q.sgn),
    .data_c (ext_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cur_d        = cur_q;
    addr_d       = addr_q;
    raw_d        = raw_q;
    mem_a_d      = mem_a;
    mem_wr_d     = mem_wr;
    mem_dout_d   = mem_dout;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cur_d.we    = req_we;
          cur_d.size  = req_size;
          cur_d.sgn   = req_signed;
          cur_d.wdata = req_wdata;
          addr_d      = ADDR_W'(req_addr);
          idx_d       = 3'd0;
          raw_d       = 32'd0;
          state_d     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (tick) begin
          if (!cur_q.we && (idx_q != 3'd0)) begin
            raw_d = raw_cap_c;
          end
          if (idx_q < n_c) begin
            mem_a_d    = addr_q + ADDR_W'(idx_q);
            mem_wr_d   = cur_q.we;
            mem_dout_d = cur_q.wdata[{idx_q[1:0], 3'b000} +: 8];
            idx_d      = idx_q + 3'd1;
          end else begin
            // Final tick: last read byte lands, bus goes quiet, respond
            mem_wr_d     = 1'b0;
            resp_valid_d = 1'b1;
            if (!cur_q.we) begin
              resp_rdata_d = ext_c;
            end
            idx_d   = 3'd0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      cur_q      <= '0;
      addr_q     <= '0;
      raw_q      <= 32'd0;
      mem_a      <= '0;
      mem_wr     <= 1'b0;
      mem_dout   <= 8'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      addr_q     <= addr_d;
      raw_q      <= raw_d;
      mem_a      <= mem_a_d;
      mem_wr     <= mem_wr_d;
      mem_dout   <= mem_dout_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
    end
  end

endmodule
